// File: rtl/note_div_pkg.sv
// Shared constants and helpers for the note divider bank: the equal-temperament
// divisor table and the semitone/octave to half-period divisor mapping.
package note_div_pkg;

    localparam logic [9:0] NOTE_DIV [12] = '{
        10'd631, 10'd596, 10'd562, 10'd531, 10'd501, 10'd473,
        10'd446, 10'd421, 10'd398, 10'd375, 10'd354, 10'd334
    };

    localparam logic [2:0] BASE_OCT = 3'd3;
    localparam logic [3:0] SEMI_MAX = 4'd11;

    // (NOTE_DIV[semi] << 3) >> oct, masked to cnt_w bits (cnt_w >= 13 keeps every value intact)
    function automatic logic [31:0] note_target(input logic [3:0] semi,
                                                input logic [2:0] oct,
                                                input int unsigned cnt_w);
        logic [3:0]  idx;
        logic [31:0] div;
        idx = (semi > SEMI_MAX) ? 4'd0 : semi;
        div = {22'd0, NOTE_DIV[idx]} << 3;
        div = div >> oct;
        if (cnt_w < 32)
            div = div & ((32'd1 << cnt_w) - 32'd1);
        return div;
    endfunction

endpackage

// File: rtl/note_div_ch.sv
// One note divider channel: input capture, registered target, half-period counter,
// wave/tick outputs. Portamento enabled by defining NOTE_DIV_GLIDE_EN.
module note_div_ch
    import note_div_pkg::*;
#(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned GLIDE_STEP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [3:0]       semi,
    input  logic [2:0]       oct,
    output logic             wave,
    output logic             tick,
    output logic [CNT_W-1:0] div_act
);

    if (CNT_W < 13) begin : g_cnt_w_check
        $error("note_div_ch: CNT_W must be at least 13");
    end
    if (GLIDE_STEP == 0 || GLIDE_STEP > 255) begin : g_step_check
        $error("note_div_ch: GLIDE_STEP must be in 1..255");
    end

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(note_target(4'd0, BASE_OCT, CNT_W));

    logic [3:0]       semi_q;
    logic [3:0]       semi_nxt;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_nxt;

    // Target is built from the values being captured this cycle, so it lands one cycle after the input
    always_comb begin
        semi_nxt   = (semi > SEMI_MAX) ? semi_q : semi;
        target_nxt = CNT_W'(note_target(semi_nxt, oct, CNT_W));
    end

`ifdef NOTE_DIV_GLIDE_EN
    localparam logic [CNT_W-1:0] STEP = CNT_W'(GLIDE_STEP);
    logic [CNT_W-1:0] diff;

    always_comb begin
        diff    = '0;
        div_nxt = target;
        if (target > div_act) begin
            diff    = target - div_act;
            div_nxt = div_act + ((diff < STEP) ? diff : STEP);
        end else if (target < div_act) begin
            diff    = div_act - target;
            div_nxt = div_act - ((diff < STEP) ? diff : STEP);
        end
    end
`else
    always_comb begin
        div_nxt = target;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            semi_q  <= '0;
            target  <= RST_DIV;
            cnt     <= '0;
            wave    <= 1'b0;
            tick    <= 1'b0;
            div_act <= RST_DIV;
        end else begin
            semi_q <= semi_nxt;
            target <= target_nxt;
            if (!en) begin
                cnt     <= '0;
                wave    <= 1'b0;
                tick    <= 1'b0;
                div_act <= target;
            end else if (cnt == div_act - 1'b1) begin
                cnt     <= '0;
                wave    <= ~wave;
                tick    <= 1'b1;
                div_act <= div_nxt;
            end else begin
                cnt     <= cnt + 1'b1;
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/note_div_bank.sv
// Bank of N_CH independent note divider channels sharing only clk/rst_n.
// Optional portamento per channel when NOTE_DIV_GLIDE_EN is defined.
module note_div_bank
    import note_div_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned GLIDE_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       ch_en,
    input  logic [4*N_CH-1:0]     semi,
    input  logic [3*N_CH-1:0]     oct,
    output logic [N_CH-1:0]       wave,
    output logic [N_CH-1:0]       tick,
    output logic [CNT_W*N_CH-1:0] div_act
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        note_div_ch #(
            .CNT_W      (CNT_W),
            .GLIDE_STEP (GLIDE_STEP)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .semi    (semi[4*i +: 4]),
            .oct     (oct[3*i +: 3]),
            .wave    (wave[i]),
            .tick    (tick[i]),
            .div_act (div_act[CNT_W*i +: CNT_W])
        );
    end

endmodule
